// File: rtl/sequencer_pkg.sv
// Shared types and helpers for the power-good conditioning stage.
//   t_pg_states     : per-rail debounce FSM states.
//   pg_params_legal : elaboration-time parameter sanity check.
package sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PG_LOW,
    ST_PG_RISE,
    ST_PG_HIGH,
    ST_PG_FALL
  } t_pg_states;

  // True when the synchroniser depth and both debounce thresholds fit the counter.
  function automatic bit pg_params_legal(input int unsigned sync_stages,
                                         input int unsigned debounce_rise,
                                         input int unsigned debounce_fall,
                                         input int unsigned cntr_size);
    int unsigned cnt_max;
    if (cntr_size < 1 || cntr_size > 31) return 1'b0;
    cnt_max = (32'd1 << cntr_size) - 32'd1;
    return (sync_stages >= 2) && (sync_stages <= 4) &&
           (debounce_rise >= 1) && (debounce_rise <= cnt_max) &&
           (debounce_fall >= 1) && (debounce_fall <= cnt_max);
  endfunction

endpackage

// File: rtl/sequencer_pg_debounce.sv
// One rail of the power-good filter: synchroniser, debounce FSM with counter,
// and the two sticky diagnostic flags.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   pg_raw_i      : raw power-good pin, asynchronous to clk_i
//   rail_ena_i    : rail enable from the rail's sequencer
//   flag_clr_i    : synchronous clear of both sticky flags
//   pg_o          : debounced power-good (registered)
//   glitch_o      : sticky, an edge failed qualification
//   unexp_o       : sticky, power-good qualified while rail disabled
module sequencer_pg_debounce
  import sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEBOUNCE_RISE = 8,
  parameter int unsigned DEBOUNCE_FALL = 2,
  parameter int unsigned C_CNTRSIZE    = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pg_raw_i,
  input  logic rail_ena_i,
  input  logic flag_clr_i,
  output logic pg_o,
  output logic glitch_o,
  output logic unexp_o
);

  localparam logic [C_CNTRSIZE-1:0] RiseLast = C_CNTRSIZE'(DEBOUNCE_RISE - 1);
  localparam logic [C_CNTRSIZE-1:0] FallLast = C_CNTRSIZE'(DEBOUNCE_FALL - 1);
  localparam logic [C_CNTRSIZE-1:0] CntOne   = {{(C_CNTRSIZE-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pg_sync;

  t_pg_states            state_q;
  logic [C_CNTRSIZE-1:0] cnt_q;
  logic                  pg_q;
  logic                  glitch_q;
  logic                  unexp_q;

  logic                  qualify;
  logic                  glitch_set;
  logic                  unexp_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pg_raw_i};
    end
  end

  assign pg_sync = sync_q[SYNC_STAGES-1];

  // Flag set conditions are decoded from the current state so that the
  // sticky update below can give set priority over clear.
  always_comb begin
    qualify    = 1'b0;
    glitch_set = 1'b0;
    unique case (state_q)
      ST_PG_LOW:  qualify = pg_sync && (DEBOUNCE_RISE == 1);
      ST_PG_RISE: begin
        qualify    = pg_sync && (cnt_q == RiseLast);
        glitch_set = !pg_sync;
      end
      ST_PG_HIGH: glitch_set = 1'b0;
      ST_PG_FALL: glitch_set = pg_sync;
      default:    glitch_set = 1'b0;
    endcase
    // Only a genuine low-to-high qualification counts; returning to high
    // from an aborted fall is not a new power-good event.
    unexp_set = qualify && !rail_ena_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_PG_LOW;
      cnt_q    <= '0;
      pg_q     <= 1'b0;
      glitch_q <= 1'b0;
      unexp_q  <= 1'b0;
    end else begin
      glitch_q <= glitch_set | (glitch_q & ~flag_clr_i);
      unexp_q  <= unexp_set | (unexp_q & ~flag_clr_i);
      unique case (state_q)
        ST_PG_LOW: begin
          cnt_q <= '0;
          if (pg_sync) begin
            if (DEBOUNCE_RISE == 1) begin
              state_q <= ST_PG_HIGH;
              pg_q    <= 1'b1;
            end else begin
              state_q <= ST_PG_RISE;
              cnt_q   <= CntOne;
            end
          end
        end
        ST_PG_RISE: begin
          if (!pg_sync) begin
            state_q <= ST_PG_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == RiseLast) begin
            state_q <= ST_PG_HIGH;
            cnt_q   <= '0;
            pg_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        ST_PG_HIGH: begin
          cnt_q <= '0;
          if (!pg_sync) begin
            if (DEBOUNCE_FALL == 1) begin
              state_q <= ST_PG_LOW;
              pg_q    <= 1'b0;
            end else begin
              state_q <= ST_PG_FALL;
              cnt_q   <= CntOne;
            end
          end
        end
        ST_PG_FALL: begin
          if (pg_sync) begin
            state_q <= ST_PG_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == FallLast) begin
            state_q <= ST_PG_LOW;
            cnt_q   <= '0;
            pg_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= ST_PG_LOW;
          cnt_q   <= '0;
          pg_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pg_o     = pg_q;
  assign glitch_o = glitch_q;
  assign unexp_o  = unexp_q;

endmodule

// File: rtl/sequencer_pg_filter.sv
// Power-good conditioning for NUM_RAILS regulators feeding the per-rail
// sequencers. Each raw pin is synchronised and debounced independently.
//   CLOCK, RESET_N  : clock, asynchronous active-low reset
//   PWRGD_RAW       : raw power-good pins (asynchronous)
//   RAIL_ENA        : rail enables from the sequencers
//   FLAG_CLR        : synchronous clear of all sticky flags
//   VRAIL_PWRGD     : debounced power-good per rail (registered)
//   GROUP_PWRGD_HI  : bit i = OR of VRAIL_PWRGD above rail i; top bit is 0
//   PG_GLITCH       : sticky, failed qualification per rail
//   UNEXP_PG        : sticky, qualified high while rail disabled
module sequencer_pg_filter
  import sequencer_pkg::*;
#(
  parameter int unsigned NUM_RAILS     = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEBOUNCE_RISE = 8,
  parameter int unsigned DEBOUNCE_FALL = 2,
  parameter int unsigned C_CNTRSIZE    = 4
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic [NUM_RAILS-1:0] PWRGD_RAW,
  input  logic [NUM_RAILS-1:0] RAIL_ENA,
  input  logic                 FLAG_CLR,
  output logic [NUM_RAILS-1:0] VRAIL_PWRGD,
  output logic [NUM_RAILS-1:0] GROUP_PWRGD_HI,
  output logic [NUM_RAILS-1:0] PG_GLITCH,
  output logic [NUM_RAILS-1:0] UNEXP_PG
);

  if (!pg_params_legal(SYNC_STAGES, DEBOUNCE_RISE, DEBOUNCE_FALL, C_CNTRSIZE)) begin : g_bad_params
    $error("sequencer_pg_filter: illegal SYNC_STAGES/DEBOUNCE_*/C_CNTRSIZE combination");
  end

  for (genvar i = 0; i < NUM_RAILS; i++) begin : g_rail
    sequencer_pg_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_RISE(DEBOUNCE_RISE),
      .DEBOUNCE_FALL(DEBOUNCE_FALL),
      .C_CNTRSIZE   (C_CNTRSIZE)
    ) u_debounce (
      .clk_i     (CLOCK),
      .rst_ni    (RESET_N),
      .pg_raw_i  (PWRGD_RAW[i]),
      .rail_ena_i(RAIL_ENA[i]),
      .flag_clr_i(FLAG_CLR),
      .pg_o      (VRAIL_PWRGD[i]),
      .glitch_o  (PG_GLITCH[i]),
      .unexp_o   (UNEXP_PG[i])
    );
  end

  // Tells rail i whether any later-sequenced rail is still up.
  for (genvar i = 0; i < NUM_RAILS; i++) begin : g_group
    if (i == NUM_RAILS - 1) begin : g_top
      assign GROUP_PWRGD_HI[i] = 1'b0;
    end else begin : g_or
      assign GROUP_PWRGD_HI[i] = |VRAIL_PWRGD[NUM_RAILS-1:i+1];
    end
  end

endmodule

// File: doc/sequencer_pg_filter.md
Name: sequencer_pg_filter

Overview:
Upstream conditioning stage for the per-rail sequencer_ctrl instances. Takes the raw, asynchronous power-good pins of NUM_RAILS regulators, synchronises and debounces each one, and produces the qualified VRAIL_PWRGD and GROUP_PWRGD_HI inputs those instances consume. Also latches sticky diagnostic flags for:
- aborted qualifications (glitches);
- power-good that qualifies while the rail is not enabled.

Parameters:
NUM_RAILS, 4, number of rails filtered; rail 0 is sequenced first, rail NUM_RAILS-1 last.
SYNC_STAGES, 2, flip-flop stages in each raw-input synchroniser; legal range 2..4.
DEBOUNCE_RISE, 8, consecutive high samples required to assert a filtered PG; legal range 1..2^C_CNTRSIZE-1.
DEBOUNCE_FALL, 2, consecutive low samples required to deassert a filtered PG; legal range 1..2^C_CNTRSIZE-1.
C_CNTRSIZE, 4, width of each per-rail debounce counter.

Ports:
CLOCK  input  1  system clock; all logic on the rising edge.
RESET_N  input  1  asynchronous, active-low reset.
PWRGD_RAW  input  NUM_RAILS  raw power-good pins, asynchronous to CLOCK.
RAIL_ENA  input  NUM_RAILS  VRAIL_ENA from each rail's sequencer_ctrl.
FLAG_CLR  input  1  synchronous clear of all sticky flags.
VRAIL_PWRGD  output  NUM_RAILS  debounced power-good per rail; registered.
GROUP_PWRGD_HI  output  NUM_RAILS  bit i = OR of VRAIL_PWRGD[j] for all j>i; bit NUM_RAILS-1 is tied 0.
PG_GLITCH  output  NUM_RAILS  sticky; an edge on rail i failed qualification.
UNEXP_PG  output  NUM_RAILS  sticky; rail i qualified high while RAIL_ENA[i]=0.

Behaviour:
Reset:
- RESET_N low asynchronously forces all synchroniser flops, counters, VRAIL_PWRGD, PG_GLITCH and UNEXP_PG to 0, and every rail FSM to ST_PG_LOW.
- Deassertion is used as-is; the synchroniser for RESET_N lives at top level.
- Reset mid-qualification discards the partial count with no flag set.

Synchroniser:
- Each PWRGD_RAW bit passes through SYNC_STAGES flops; the last stage output is s[i].
- Only s[i] is used downstream.

Per-rail FSM (enum t_pg_states), all transitions registered:
- ST_PG_LOW: cnt=0. If s=1: when DEBOUNCE_RISE==1, go to ST_PG_HIGH; otherwise go to ST_PG_RISE with cnt=1.
- ST_PG_RISE:
  - s=1 and cnt==DEBOUNCE_RISE-1: go to ST_PG_HIGH, cnt=0.
  - s=1 otherwise: cnt++.
  - s=0: go to ST_PG_LOW, set PG_GLITCH[i].
- ST_PG_HIGH: cnt=0. If s=0: when DEBOUNCE_FALL==1, go to ST_PG_LOW; otherwise go to ST_PG_FALL with cnt=1.
- ST_PG_FALL:
  - s=0 and cnt==DEBOUNCE_FALL-1: go to ST_PG_LOW, cnt=0.
  - s=0 otherwise: cnt++.
  - s=1: go to ST_PG_HIGH, set PG_GLITCH[i].

Filtered output and latency:
- VRAIL_PWRGD[i] is a register loaded with 1 on entry to ST_PG_HIGH and 0 on entry to ST_PG_LOW.
- It therefore stays 1 throughout ST_PG_FALL and 0 throughout ST_PG_RISE.
- Latency from a clean raw edge (setup met) to the VRAIL_PWRGD change:
  - rising edge: exactly SYNC_STAGES+DEBOUNCE_RISE rising CLOCK edges (defaults: 10);
  - falling edge: exactly SYNC_STAGES+DEBOUNCE_FALL rising CLOCK edges (defaults: 4).
- The counter never exceeds max(DEBOUNCE_RISE, DEBOUNCE_FALL)-1, so it never wraps.

GROUP_PWRGD_HI:
- Purely combinational from the VRAIL_PWRGD registers; adds no latency.
- It changes on the same edge as the VRAIL_PWRGD bit that drives it.

UNEXP_PG[i]:
- Set on the edge where rail i enters ST_PG_HIGH while RAIL_ENA[i]=0.
- PG that remains high after RAIL_ENA drops (power-down) does not set it.

Sticky flag clearing:
- FLAG_CLR=1 clears all PG_GLITCH and UNEXP_PG bits on the next edge.
- A set condition on the same edge as FLAG_CLR wins: the bit reads 1.

Rails are fully independent; simultaneous events on different rails do not interact.

Decomposition:
- Shared package sequencer_pkg holds:
  - the t_pg_states enum (ST_PG_LOW, ST_PG_RISE, ST_PG_HIGH, ST_PG_FALL);
  - a parameter-legality check function used by elaboration-time assertions.
- Sub-module sequencer_pg_debounce: one rail, containing the synchroniser, FSM, counter and both sticky flags.
- Top level generates NUM_RAILS instances and the GROUP_PWRGD_HI OR-reduction.

Test Plan:
1. Reset, then PWRGD_RAW[0] held high → VRAIL_PWRGD[0] rises exactly 10 edges later; GROUP_PWRGD_HI stays 0 when only rail 0 is high.
2. RAIL_ENA=0 on all rails, then PWRGD_RAW[1] pulsed high for 5 cycles → VRAIL_PWRGD[1] stays 0, PG_GLITCH[1]=1 after the pulse ends, UNEXP_PG[1]=0.
3. Rails 2 and 3 qualified high with RAIL_ENA=1111 → GROUP_PWRGD_HI=0111 (bits 0,1,2 high); drop raw PG 3 → GROUP_PWRGD_HI=0011 exactly 4 edges later.
4. Rail 0 high; raw PG 0 low for 1 cycle → output stays 1, PG_GLITCH[0]=1. Then FLAG_CLR pulsed while raw PG 0 is low for 1 cycle again (reported on the FLAG_CLR edge) → PG_GLITCH[0] remains 1 because set wins.
5. RAIL_ENA[2]=0 and PWRGD_RAW[2] held high → UNEXP_PG[2]=1 on the qualification edge; FLAG_CLR → 0 on the next edge while VRAIL_PWRGD[2] stays 1.
6. RESET_N asserted mid-ST_PG_RISE (count 5) and mid-ST_PG_HIGH → all outputs 0 immediately (asynchronously); after release with raw still high, full 10-edge qualification restarts and no glitch is flagged.
